// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: branch opcodes, BHT counter type,
// and the 2-bit saturating counter update rule.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_JALR = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JAL  = 3'd7
  } br_op_e;

  typedef logic [1:0] ctr_t;

  // Weakly not-taken: a single taken outcome flips the prediction.
  localparam ctr_t BHT_RESET = 2'b01;

  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    if (taken) return (cur == 2'b11) ? cur : cur + 2'd1;
    else       return (cur == 2'b00) ? cur : cur - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-stage branch bus: instruction operands in, redirect and link address out.
// The master is the pipeline side, the slave is the branch resolve unit.
interface branch_resolve_unit_if
  import branch_pkg::*;
#(
  parameter int DATA_SIZE = 32
);
  logic                 br_valid;
  br_op_e               br_op;
  logic                 br_pred_taken;
  logic [DATA_SIZE-1:0] pc;
  logic [DATA_SIZE-1:0] src1;
  logic [DATA_SIZE-1:0] src2;
  logic [DATA_SIZE-1:0] imm_data;
  logic                 stall;
  logic                 redirect_valid;
  logic [DATA_SIZE-1:0] redirect_pc;
  logic [DATA_SIZE-1:0] link_addr;

  modport master (
    output br_valid, br_op, br_pred_taken, pc, src1, src2, imm_data, stall,
    input  redirect_valid, redirect_pc, link_addr
  );

  modport slave (
    input  br_valid, br_op, br_pred_taken, pc, src1, src2, imm_data, stall,
    output redirect_valid, redirect_pc, link_addr
  );
endinterface

// File: rtl/branch_bht.sv
// Branch history table of 2-bit saturating counters: asynchronous read for
// fetch, one read-modify-write update port for resolved conditional branches.
module branch_bht
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr_t             rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr_t mem [BHT_ENTRIES];

  // Read sees the stored value even when the same entry is updated this cycle.
  assign rd_ctr = mem[rd_idx];

  // NOTE: this table must be reset entry by entry so predictions start weakly
  // not-taken; that forces flops rather than a RAM macro, which is fine at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) mem[i] <= BHT_RESET;
    end else if (wr_en) begin
      mem[wr_idx] <= ctr_next(mem[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches and jumps, trains the BHT, registers a one-cycle
// IF redirect on mispredict and keeps saturating branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 32,
  localparam int IDX_W      = $clog2(BHT_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_SIZE-1:0] fetch_pc,
  output logic                 fetch_pred_taken,
  branch_resolve_unit_if.slave ex,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  logic                 accept;
  logic                 is_cond;
  logic                 taken;
  logic                 mispred;
  logic                 do_redirect;
  logic [DATA_SIZE-1:0] sum;
  logic [DATA_SIZE-1:0] target;
  logic [DATA_SIZE-1:0] pc_plus4;
  logic [DATA_SIZE-1:0] corrected_pc;
  logic                 redirect_valid_q;
  logic [DATA_SIZE-1:0] redirect_pc_q;
  ctr_t                 fetch_ctr;

  // Fetch PC bits outside the word index do not take part in the lookup.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[DATA_SIZE-1:IDX_W+2], fetch_pc[1:0]};

  // An instruction in EX while a redirect is pulsing is on the wrong path.
  assign accept  = ex.br_valid & ~ex.stall & ~redirect_valid_q;
  assign is_cond = (ex.br_op != BR_JAL) && (ex.br_op != BR_JALR);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    taken = 1'b0;
    unique case (ex.br_op)
      BR_BEQ:  taken = (ex.src1 == ex.src2);
      BR_BNE:  taken = (ex.src1 != ex.src2);
      BR_BLT:  taken = ($signed(ex.src1) <  $signed(ex.src2));
      BR_BGE:  taken = ($signed(ex.src1) >= $signed(ex.src2));
      BR_BLTU: taken = (ex.src1 <  ex.src2);
      BR_BGEU: taken = (ex.src1 >= ex.src2);
      BR_JAL,
      BR_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign sum      = ((ex.br_op == BR_JALR) ? ex.src1 : ex.pc) + ex.imm_data;
  assign target   = (ex.br_op == BR_JALR) ? {sum[DATA_SIZE-1:1], 1'b0} : sum;
  assign pc_plus4 = ex.pc + DATA_SIZE'(4);

  // IF never predicts jumps, so a jump always costs a redirect.
  assign mispred      = is_cond ? (taken != ex.br_pred_taken) : 1'b1;
  assign corrected_pc = taken ? target : pc_plus4;
  assign do_redirect  = accept & mispred;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      branch_cnt       <= '0;
      mispred_cnt      <= '0;
    end else begin
      redirect_valid_q <= do_redirect;
      if (do_redirect) redirect_pc_q <= corrected_pc;
      if (accept && is_cond && branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (do_redirect && mispred_cnt != '1)
        mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

  assign ex.redirect_valid = redirect_valid_q;
  assign ex.redirect_pc    = redirect_pc_q;
  assign ex.link_addr      = pc_plus4;

  branch_bht #(
    .BHT_ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_pc[IDX_W+1:2]),
    .rd_ctr   (fetch_ctr),
    .wr_en    (accept & is_cond),
    .wr_idx   (ex.pc[IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign fetch_pred_taken = fetch_ctr[1];

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed-vector bench for branch_resolve_unit: resolution, redirect timing,
// BHT training/aliasing, stall and wrong-path handling, reset, counter saturation.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        fetch_pred_taken;
  logic [31:0] branch_cnt, mispred_cnt;
  logic [31:0] fetch_pc_s = '0;
  logic        fetch_pred_s;
  logic [1:0]  branch_cnt_s, mispred_cnt_s;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DATA_SIZE(32)) ex ();
  branch_resolve_unit_if #(.DATA_SIZE(32)) ex_s ();

  branch_resolve_unit #(
    .DATA_SIZE (32), .BHT_ENTRIES (64), .CNT_WIDTH (32)
  ) dut (
    .clk (clk), .rst (rst), .fetch_pc (fetch_pc), .fetch_pred_taken (fetch_pred_taken),
    .ex (ex.slave), .branch_cnt (branch_cnt), .mispred_cnt (mispred_cnt)
  );

  // Narrow counters make saturation reachable in a few cycles.
  branch_resolve_unit #(
    .DATA_SIZE (32), .BHT_ENTRIES (64), .CNT_WIDTH (2)
  ) dut_sat (
    .clk (clk), .rst (rst), .fetch_pc (fetch_pc_s), .fetch_pred_taken (fetch_pred_s),
    .ex (ex_s.slave), .branch_cnt (branch_cnt_s), .mispred_cnt (mispred_cnt_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input br_op_e op, input logic pred, input logic [31:0] pc,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm);
    ex.br_valid      = 1'b1;
    ex.br_op         = op;
    ex.br_pred_taken = pred;
    ex.pc            = pc;
    ex.src1          = s1;
    ex.src2          = s2;
    ex.imm_data      = imm;
  endtask

  task automatic drive_s(input br_op_e op, input logic pred);
    ex_s.br_valid      = 1'b1;
    ex_s.br_op         = op;
    ex_s.br_pred_taken = pred;
    ex_s.pc            = 32'h100;
    ex_s.src1          = 32'd7;
    ex_s.src2          = 32'd7;
    ex_s.imm_data      = 32'h40;
  endtask

  initial begin
    ex.br_valid = 1'b0; ex.br_op = BR_BEQ; ex.br_pred_taken = 1'b0; ex.stall = 1'b0;
    ex.pc = '0; ex.src1 = '0; ex.src2 = '0; ex.imm_data = '0;
    ex_s.br_valid = 1'b0; ex_s.br_op = BR_BEQ; ex_s.br_pred_taken = 1'b0; ex_s.stall = 1'b0;
    ex_s.pc = '0; ex_s.src1 = '0; ex_s.src2 = '0; ex_s.imm_data = '0;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    fetch_pc = 32'h40;
    #1;
    check("rst_pred", fetch_pred_taken, 1'b0);
    check("rst_rv", ex.redirect_valid, 1'b0);
    check("rst_rpc", ex.redirect_pc, 32'h0);
    check("rst_bcnt", branch_cnt, 32'h0);
    check("rst_mcnt", mispred_cnt, 32'h0);

    // BEQ taken, predicted not-taken: redirect to pc+imm in N+1 only
    drive(BR_BEQ, 1'b0, 32'h100, 32'd5, 32'd5, 32'h20);
    #1;
    check("beq_link", ex.link_addr, 32'h104);
    check("beq_rv_n", ex.redirect_valid, 1'b0);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("beq_rv", ex.redirect_valid, 1'b1);
    check("beq_rpc", ex.redirect_pc, 32'h120);
    check("beq_mcnt", mispred_cnt, 32'd1);
    check("beq_bcnt", branch_cnt, 32'd1);
    fetch_pc = 32'h100;
    #1;
    check("beq_bht0", fetch_pred_taken, 1'b1);
    tick();
    check("beq_rv_n2", ex.redirect_valid, 1'b0);
    check("beq_rpc_hold", ex.redirect_pc, 32'h120);

    // BLT signed: -1 < 1 taken, predicted taken: no redirect
    drive(BR_BLT, 1'b1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("blt_rv", ex.redirect_valid, 1'b0);
    check("blt_bcnt", branch_cnt, 32'd2);
    check("blt_mcnt", mispred_cnt, 32'd1);

    // BLTU: 0xFFFFFFFF < 1 false, predicted taken: redirect to pc+4
    drive(BR_BLTU, 1'b1, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("bltu_rv", ex.redirect_valid, 1'b1);
    check("bltu_rpc", ex.redirect_pc, 32'h304);
    check("bltu_bcnt", branch_cnt, 32'd3);
    check("bltu_mcnt", mispred_cnt, 32'd2);
    tick();

    // JALR: target bit0 cleared, link = pc+4, no BHT or branch_cnt change
    fetch_pc = 32'h504;
    drive(BR_JALR, 1'b0, 32'h504, 32'h203, 32'd0, 32'h10);
    #1;
    check("jalr_link", ex.link_addr, 32'h508);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("jalr_rv", ex.redirect_valid, 1'b1);
    check("jalr_rpc", ex.redirect_pc, 32'h212);
    check("jalr_bcnt", branch_cnt, 32'd3);
    check("jalr_mcnt", mispred_cnt, 32'd3);
    check("jalr_bht", fetch_pred_taken, 1'b0);
    tick();

    // Four taken BNE at 0x40 train BHT[16]; 0x140 aliases onto it
    fetch_pc = 32'h40;
    drive(BR_BNE, 1'b1, 32'h40, 32'd1, 32'd2, 32'h8);
    #1;
    check("bne_pre", fetch_pred_taken, 1'b0);
    tick();
    check("bne_1", fetch_pred_taken, 1'b1);
    fetch_pc = 32'h140;
    #1;
    check("bne_alias", fetch_pred_taken, 1'b1);
    fetch_pc = 32'h44;
    #1;
    check("bne_neighbor", fetch_pred_taken, 1'b0);
    fetch_pc = 32'h40;
    tick(); tick(); tick();
    check("bne_rv", ex.redirect_valid, 1'b0);
    // Saturated at 11: one not-taken still predicts taken, a second does not
    drive(BR_BNE, 1'b0, 32'h40, 32'd3, 32'd3, 32'h8);
    tick();
    check("bne_sat_nt1", fetch_pred_taken, 1'b1);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("bne_sat_nt2", fetch_pred_taken, 1'b0);
    check("bne_bcnt", branch_cnt, 32'd9);
    check("bne_mcnt", mispred_cnt, 32'd3);

    // Wrong-path BEQ right behind a mispredict is ignored
    drive(BR_BEQ, 1'b0, 32'h600, 32'd1, 32'd1, 32'h100);
    tick();
    drive(BR_BEQ, 1'b0, 32'h800, 32'd1, 32'd1, 32'h10);
    #1;
    check("wp_rv", ex.redirect_valid, 1'b1);
    check("wp_rpc", ex.redirect_pc, 32'h700);
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("wp_rv_n2", ex.redirect_valid, 1'b0);
    check("wp_rpc_hold", ex.redirect_pc, 32'h700);
    check("wp_mcnt", mispred_cnt, 32'd4);
    check("wp_bcnt", branch_cnt, 32'd10);

    // Stall holds the instruction until it drops
    drive(BR_BEQ, 1'b0, 32'h900, 32'd2, 32'd2, 32'h4);
    ex.stall = 1'b1;
    tick(); tick();
    check("stall_rv", ex.redirect_valid, 1'b0);
    check("stall_mcnt", mispred_cnt, 32'd4);
    check("stall_bcnt", branch_cnt, 32'd10);
    ex.stall = 1'b0;
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("unstall_rv", ex.redirect_valid, 1'b1);
    check("unstall_rpc", ex.redirect_pc, 32'h904);
    check("unstall_mcnt", mispred_cnt, 32'd5);
    check("unstall_bcnt", branch_cnt, 32'd11);
    tick();

    // Reset in the cycle after an accept drops the pending redirect
    drive(BR_JAL, 1'b0, 32'hA00, 32'd0, 32'd0, 32'h20);
    fetch_pc = 32'h100;
    tick();
    ex.br_valid = 1'b0;
    #1;
    check("jal_rv", ex.redirect_valid, 1'b1);
    check("jal_rpc", ex.redirect_pc, 32'hA20);
    rst = 1'b1;
    tick();
    check("rst2_rv", ex.redirect_valid, 1'b0);
    check("rst2_rpc", ex.redirect_pc, 32'h0);
    check("rst2_bcnt", branch_cnt, 32'h0);
    check("rst2_mcnt", mispred_cnt, 32'h0);
    check("rst2_bht", fetch_pred_taken, 1'b0);
    rst = 1'b0;

    // Narrow counters saturate at all-ones
    for (int i = 1; i <= 4; i++) begin
      drive_s(BR_JAL, 1'b0);
      tick();
      ex_s.br_valid = 1'b0;
      #1;
      check($sformatf("sat_mcnt_%0d", i), mispred_cnt_s, (i > 3) ? 2'd3 : 2'(i));
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      drive_s(BR_BEQ, 1'b1);
      tick();
      ex_s.br_valid = 1'b0;
      #1;
      check($sformatf("sat_bcnt_%0d", i), branch_cnt_s, (i > 3) ? 2'd3 : 2'(i));
    end
    check("sat_mcnt_hold", mispred_cnt_s, 2'd3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
